// File: rtl/ask4_sym_detector.sv
// 4-ASK receive symbol detector: picks a sample phase and slices against a self-calibrating level.
// It reports the decision, the level, the error and a windowed mean-squared error.
module ask4_sym_detector #(
  parameter int LOG2_N = 10
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic signed [17:0] dec_in,
  input  logic [1:0]         phase_sel,
  input  logic               clr_acc,
  output logic signed [17:0] dec_var,
  output logic [1:0]         slice,
  output logic signed [17:0] level,
  output logic signed [17:0] error,
  output logic               sym_valid,
  output logic signed [17:0] ref_lvl,
  output logic               ref_valid,
  output logic [35:0]        mse,
  output logic               mse_valid
);

  localparam int MAG_W = 17 + LOG2_N;
  localparam int ESQ_W = 36 + LOG2_N;

  logic signed [17:0] dly_reg [4];
  logic               s1_valid_reg, s1_clr_reg;
  logic               s2_valid_reg, s2_clr_reg;
  logic               s3_valid_reg, s3_clr_reg;
  logic [MAG_W-1:0]   mag_acc_reg;
  logic [LOG2_N-1:0]  mag_cnt_reg;
  logic [35:0]        err_sq_reg;
  logic [ESQ_W-1:0]   err_acc_reg;
  logic [LOG2_N-1:0]  err_cnt_reg;

  function automatic logic signed [17:0] sat18(input logic signed [19:0] v);
    if (v > 20'sd131071)
      return 18'sd131071;
    else if (v < -20'sd131072)
      return {1'b1, 17'd0};
    else
      return 18'(v);
  endfunction

  // Delay line; the capture reads the taps before this edge's shift.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) dly_reg[k] <= '0;
      dec_var      <= '0;
      s1_valid_reg <= 1'b0;
      s1_clr_reg   <= 1'b0;
    end else begin
      if (sam_clk_en) begin
        dly_reg[0] <= dec_in;
        for (int k = 1; k < 4; k++) dly_reg[k] <= dly_reg[k-1];
      end
      if (sym_clk_en) dec_var <= dly_reg[phase_sel];
      s1_valid_reg <= sym_clk_en;
      s1_clr_reg   <= sym_clk_en & clr_acc;
    end
  end

  logic signed [19:0] x_ext, r_ext, two_r, three_r, level_wide, diff_wide;
  logic [1:0]         slice_next;
  logic signed [17:0] level_next, error_next, neg_dec;
  logic [16:0]        mag_next;

  always_comb begin
    x_ext   = 20'(dec_var);
    r_ext   = 20'(ref_lvl);
    two_r   = r_ext <<< 1;
    three_r = two_r + r_ext;
    if (x_ext >= two_r)
      slice_next = 2'b11;
    else if (x_ext >= 20'sd0)
      slice_next = 2'b10;
    else if (x_ext >= -two_r)
      slice_next = 2'b01;
    else
      slice_next = 2'b00;
    case (slice_next)
      2'b11:   level_wide = three_r;
      2'b10:   level_wide = r_ext;
      2'b01:   level_wide = -r_ext;
      default: level_wide = -three_r;
    endcase
    level_next = sat18(level_wide);
    diff_wide  = x_ext - 20'(level_next);
    error_next = sat18(diff_wide);
    // -131072 has no positive twin in 17 bits; clamp it to full scale.
    neg_dec = -dec_var;
    if (!dec_var[17])
      mag_next = dec_var[16:0];
    else if (dec_var[16:0] == 17'd0)
      mag_next = 17'h1FFFF;
    else
      mag_next = neg_dec[16:0];
  end

  logic [MAG_W-1:0] mag_sum;
  assign mag_sum = mag_acc_reg + MAG_W'(mag_next);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      slice        <= 2'b00;
      level        <= '0;
      error        <= '0;
      sym_valid    <= 1'b0;
      ref_lvl      <= '0;
      ref_valid    <= 1'b0;
      mag_acc_reg  <= '0;
      mag_cnt_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_clr_reg   <= 1'b0;
    end else begin
      sym_valid    <= s1_valid_reg;
      s2_valid_reg <= s1_valid_reg;
      s2_clr_reg   <= s1_clr_reg;
      if (s1_valid_reg) begin
        slice <= slice_next;
        level <= level_next;
        error <= error_next;
        if (s1_clr_reg) begin
          mag_acc_reg <= MAG_W'(mag_next);
          mag_cnt_reg <= LOG2_N'(1);
        end else if (&mag_cnt_reg) begin
          // Reference a is half the mean magnitude of the window.
          ref_lvl     <= {2'b00, mag_sum[LOG2_N+1 +: 16]};
          ref_valid   <= 1'b1;
          mag_acc_reg <= '0;
          mag_cnt_reg <= '0;
        end else begin
          mag_acc_reg <= mag_sum;
          mag_cnt_reg <= mag_cnt_reg + LOG2_N'(1);
        end
      end
    end
  end

  logic signed [35:0] err_prod;
  assign err_prod = 36'(error) * 36'(error);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      err_sq_reg   <= '0;
      s3_valid_reg <= 1'b0;
      s3_clr_reg   <= 1'b0;
    end else begin
      if (s2_valid_reg) err_sq_reg <= err_prod;
      s3_valid_reg <= s2_valid_reg;
      s3_clr_reg   <= s2_clr_reg;
    end
  end

  logic [ESQ_W-1:0] err_sum;
  assign err_sum = err_acc_reg + ESQ_W'(err_sq_reg);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      err_acc_reg <= '0;
      err_cnt_reg <= '0;
      mse         <= '0;
      mse_valid   <= 1'b0;
    end else begin
      mse_valid <= 1'b0;
      if (s3_valid_reg) begin
        if (s3_clr_reg) begin
          err_acc_reg <= ESQ_W'(err_sq_reg);
          err_cnt_reg <= LOG2_N'(1);
        end else if (&err_cnt_reg) begin
          mse         <= err_sum[LOG2_N +: 36];
          mse_valid   <= 1'b1;
          err_acc_reg <= '0;
          err_cnt_reg <= '0;
        end else begin
          err_acc_reg <= err_sum;
          err_cnt_reg <= err_cnt_reg + LOG2_N'(1);
        end
      end
    end
  end

endmodule
